hbridge_pwm: RTL and testbench

- Downstream stage of the signed command clamp: consumes the saturated signed command (±LIMIT) and turns it into a complementary half-bridge PWM pair plus a direction bit.
- Magnitude sets duty over a fixed period; sign sets DIR.
- Command is double-buffered at the period boundary.
- Dead-time insertion guarantees H and L are never both on.

---
 rtl/hbridge_pwm.sv | 158 +++++++++++++++
 tb/tb_hbridge_pwm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_pwm.sv
// Complementary half-bridge PWM with dead-time from a saturated signed command.
// Optional fault latch is enabled by defining HBRIDGE_FAULT_LATCH_EN.
module hbridge_pwm #(
    parameter int BITS     = 11,
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EN,
    input  logic [BITS-1:0] IN,
`ifdef HBRIDGE_FAULT_LATCH_EN
    input  logic            FAULT_N,
    input  logic            FAULT_CLR,
    output logic            FAULTED,
`endif
    output logic            PWM_H,
    output logic            PWM_L,
    output logic            DIR,
    output logic            PERIOD_TICK
);

    localparam int CW = $clog2(PERIOD);
    localparam int MW = $clog2(PERIOD + 1);
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [MW-1:0] MAG_FULL = MW'(PERIOD);
    localparam logic [DW-1:0] DT_LOAD  = DW'(DEADTIME - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_LOW,
        ST_DEAD_R,
        ST_HIGH,
        ST_DEAD_F
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mag_sh_q, mag_sh_d;
    logic [DW-1:0] dt_q, dt_d;
    logic          dir_q, dir_d;
    logic          run_prev_q, run_prev_d;
    logic          pwm_h_q, pwm_h_d;
    logic          pwm_l_q, pwm_l_d;

    logic          run;
    logic          load;
    logic          raw;
    logic [BITS:0] in_ext;
    logic [BITS:0] in_abs;

`ifdef HBRIDGE_FAULT_LATCH_EN
    logic faulted_q, faulted_d;

    // Fault wins over clear; a latched fault keeps the bridge off until cleared,
    // and the clear edge itself still counts as disabled so restart is clean.
    assign faulted_d = ~FAULT_N | (faulted_q & ~FAULT_CLR);
    assign run       = EN & FAULT_N & ~faulted_q;
    assign FAULTED   = faulted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) faulted_q <= 1'b0;
        else      faulted_q <= faulted_d;
    end
`else
    assign run = EN;
`endif

    always_comb begin
        in_ext = {IN[BITS-1], IN};
        in_abs = IN[BITS-1] ? -in_ext : in_ext;
        load   = run & (~run_prev_q | (cnt_q == CNT_LAST));
        raw    = (MW'(cnt_q) < mag_sh_q);

        run_prev_d = run;

        cnt_d = '0;
        if (run) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

        // Shadow registers only change at the period boundary (or restart).
        mag_sh_d = mag_sh_q;
        dir_d    = dir_q;
        if (load) begin
            dir_d = IN[BITS-1];
            if (int'(in_abs) > PERIOD) mag_sh_d = MAG_FULL;
            else                       mag_sh_d = MW'(in_abs);
        end
    end

    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (!run) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: state_d = ST_LOW;
                ST_LOW: begin
                    if (raw) begin
                        state_d = ST_DEAD_R;
                        dt_d    = DT_LOAD;
                    end
                end
                ST_DEAD_R: begin
                    if (!raw)            state_d = ST_LOW;
                    else if (dt_q == '0) state_d = ST_HIGH;
                    else                 dt_d    = dt_q - DW'(1);
                end
                ST_HIGH: begin
                    if (!raw) begin
                        state_d = ST_DEAD_F;
                        dt_d    = DT_LOAD;
                    end
                end
                ST_DEAD_F: begin
                    if (raw)             state_d = ST_HIGH;
                    else if (dt_q == '0) state_d = ST_LOW;
                    else                 dt_d    = dt_q - DW'(1);
                end
                default: state_d = ST_OFF;
            endcase
        end
        // Gate drives are the registered decode of the next state, so they
        // track the state one-for-one yet can be cleared by reset alone.
        pwm_h_d = (state_d == ST_HIGH);
        pwm_l_d = (state_d == ST_LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            mag_sh_q   <= '0;
            dt_q       <= '0;
            dir_q      <= 1'b0;
            run_prev_q <= 1'b0;
            pwm_h_q    <= 1'b0;
            pwm_l_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_sh_q   <= mag_sh_d;
            dt_q       <= dt_d;
            dir_q      <= dir_d;
            run_prev_q <= run_prev_d;
            pwm_h_q    <= pwm_h_d;
            pwm_l_q    <= pwm_l_d;
        end
    end

    assign PWM_H       = pwm_h_q;
    assign PWM_L       = pwm_l_q;
    assign DIR         = dir_q;
    assign PERIOD_TICK = run & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_hbridge_pwm.sv
// Directed and randomized checks of hbridge_pwm at PERIOD=1000, DEADTIME=8.
module tb_hbridge_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic [10:0] IN_v;
    logic        pwm_h, pwm_l, dir, ptick;
`ifdef HBRIDGE_FAULT_LATCH_EN
    logic        fault_n, fault_clr, faulted;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_h, m_l, m_off, m_tick, m_dir, m_first_h, m_last_h;
    logic en_cur;

    hbridge_pwm #(.BITS(11), .PERIOD(1000), .DEADTIME(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .EN          (EN),
        .IN          (IN_v),
`ifdef HBRIDGE_FAULT_LATCH_EN
        .FAULT_N     (fault_n),
        .FAULT_CLR   (fault_clr),
        .FAULTED     (faulted),
`endif
        .PWM_H       (pwm_h),
        .PWM_L       (pwm_l),
        .DIR         (dir),
        .PERIOD_TICK (ptick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Starts on the cnt=0 sample, returns on the next cnt=0 sample.
    // IN is set to a at cnt=0 and b at cnt=500; b is what the boundary loads.
    task automatic measure(input int a, input int b);
        m_h = 0; m_l = 0; m_off = 0; m_tick = 0; m_dir = 0;
        m_first_h = -1; m_last_h = -1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0)   IN_v = 11'(a);
            if (i == 500) IN_v = 11'(b);
            if (pwm_h) begin
                m_h++;
                if (m_first_h < 0) m_first_h = i;
                m_last_h = i;
            end
            if (pwm_l) m_l++;
            if (!pwm_h && !pwm_l) m_off++;
            if (ptick) m_tick++;
            if (dir) m_dir++;
            step();
        end
        $display("period in=%0d/%0d: h=%0d l=%0d off=%0d tick=%0d dir=%0d first_h=%0d last_h=%0d",
                 a, b, m_h, m_l, m_off, m_tick, m_dir, m_first_h, m_last_h);
    endtask

    task automatic check_period(input string tag, input int h, input int l, input int d);
        check({tag, ".h"},   m_h,   h);
        check({tag, ".l"},   m_l,   l);
        check({tag, ".dir"}, m_dir, d);
        check({tag, ".tick"}, m_tick, 1);
    endtask

    initial begin
        rst  = 1'b0;
        EN   = 1'b0;
        IN_v = '0;
`ifdef HBRIDGE_FAULT_LATCH_EN
        fault_n   = 1'b1;
        fault_clr = 1'b0;
`endif
        wait_cycles(2);
        check("rst.h", pwm_h, 0);
        check("rst.l", pwm_l, 0);
        check("rst.dir", dir, 0);
        check("rst.tick", ptick, 0);
`ifdef HBRIDGE_FAULT_LATCH_EN
        check("rst.faulted", faulted, 0);
`endif
        rst = 1'b1;
        wait_cycles(2);
        check("dis.h", pwm_h, 0);
        check("dis.l", pwm_l, 0);

        // Enable: L asserts one cycle later; first load happens on that cycle.
        EN = 1'b1; IN_v = 11'(250);
        step();
        check("en.l", pwm_l, 1);
        check("en.h", pwm_h, 0);
        wait_cycles(999);

        measure(250, 250);
        check_period("p250", 242, 742, 0);
        check("p250.first_h", m_first_h, 9);
        check("p250.last_h", m_last_h, 250);
        check("p250.off", m_off, 16);

        measure(0, -250);
        check_period("mid_ignored", 242, 742, 0);
        measure(5, 0);
        check_period("neg250", 242, 742, 1000);
        check("neg250.first_h", m_first_h, 9);
        check("neg250.last_h", m_last_h, 250);
        measure(0, 1000);
        check_period("zero", 0, 1000, 0);
        measure(1000, -1024);
        check_period("full_first", 991, 1, 0);
        check("full_first.first_h", m_first_h, 9);
        measure(-1024, 5);
        check_period("full_neg", 1000, 0, 1000);
        measure(5, 5);
        check_period("full_to5", 6, 986, 0);
        measure(5, 250);
        check_period("small5", 0, 995, 0);
        check("small5.off", m_off, 5);

        // Random command every cycle with occasional enable toggles.
        for (int c = 0; c < 20000; c++) begin
            IN_v = 11'($urandom);
            if ($urandom_range(0, 199) == 0) EN = ~EN;
            en_cur = EN;
            step();
            check("excl", {31'd0, pwm_h & pwm_l}, 0);
            if (!en_cur) check("en0_off", {29'd0, ptick, pwm_h, pwm_l}, 0);
        end

        // Disable then restart: counter must restart from 0.
        EN = 1'b0;
        step();
        check("dis2.h", pwm_h, 0);
        check("dis2.l", pwm_l, 0);
        check("dis2.tick", ptick, 0);
        EN = 1'b1;
        step();
        check("restart.l", pwm_l, 1);
        wait_cycles(997);
        check("restart.tick998", ptick, 0);
        step();
        check("restart.tick999", ptick, 1);

        // Asynchronous reset while H is on.
        IN_v = 11'(500);
        step();
        wait_cycles(400);
        check("pre_rst.h", pwm_h, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst.h", pwm_h, 0);
        check("async_rst.l", pwm_l, 0);
        check("async_rst.dir", dir, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        IN_v = '0;
        step();
        check("post_rst.l", pwm_l, 1);
        wait_cycles(997);
        check("post_rst.tick998", ptick, 0);
        step();
        check("post_rst.tick999", ptick, 1);

`ifdef HBRIDGE_FAULT_LATCH_EN
        IN_v = 11'(500);
        step();
        wait_cycles(100);
        fault_n = 1'b0;
        step();
        fault_n = 1'b1;
        check("fault.set", faulted, 1);
        check("fault.h", pwm_h, 0);
        check("fault.l", pwm_l, 0);
        wait_cycles(5);
        check("fault.hold", faulted, 1);
        check("fault.hold_l", pwm_l, 0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("fault.clr", faulted, 0);
        check("fault.clr_l", pwm_l, 0);
        step();
        check("fault.restart_l", pwm_l, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
